// File: rtl/keysearch_pkg.sv
// Shared widths, status encoding and a saturating-increment helper for the
// DES key-search datapath.
package keysearch_pkg;

  localparam int KEY_W = 56;
  localparam int BLK_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    HIT,
    EXHAUSTED
  } status_t;

  // Attempt counter holds at all-ones rather than wrapping to zero.
  function automatic logic [KEY_W-1:0] sat_inc(input logic [KEY_W-1:0] v);
    return (&v) ? v : v + KEY_W'(1);
  endfunction

endpackage

// File: rtl/keysearch_datapath_key_counter.sv
// Loadable candidate-key counter. The prime bit swallows the first advance so
// that the first key tested after a load is the loaded value itself.
import keysearch_pkg::*;

module key_counter (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [KEY_W-1:0] start,
  input  logic             inc,
  output logic [KEY_W-1:0] count,
  output logic             primed
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      primed <= 1'b0;
    end else if (load) begin
      count  <= start;
      primed <= 1'b0;
    end else if (inc) begin
      if (!primed) begin
        primed <= 1'b1;
      end else begin
        count <= count + KEY_W'(1);
      end
    end
  end

endmodule

// File: rtl/keysearch_datapath.sv
// Key-search datapath: candidate counter, ciphertext comparator, status FSM
// and result registers answering the controller's up/en1/en2 strobes.
import keysearch_pkg::*;

module keysearch_datapath (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [KEY_W-1:0] key_start,
  input  logic [KEY_W-1:0] key_end,
  input  logic [BLK_W-1:0] target_ct,
  input  logic             up,
  input  logic             en1,
  input  logic             en2,
  output logic [KEY_W-1:0] cand_key,
  input  logic [BLK_W-1:0] des_ct,
  output logic             key_found,
  output logic             key_hit,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic             result_valid,
  output logic [KEY_W-1:0] attempts
);

  status_t          state_reg, state_next;
  logic [KEY_W-1:0] key_end_reg;
  logic [BLK_W-1:0] target_ct_reg;
  logic [KEY_W-1:0] found_key_reg;
  logic [KEY_W-1:0] attempts_reg;
  logic             result_valid_reg;
  logic             primed;

  logic in_search, in_done, test, match, last;

  assign in_search = (state_reg == SEARCH);
  assign in_done   = (state_reg == HIT) || (state_reg == EXHAUSTED);
  assign test      = in_search && en1 && !clear;
  assign match     = (des_ct == target_ct_reg);
  assign last      = (cand_key == key_end_reg);

  key_counter u_key_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (clear),
    .start   (key_start),
    .inc     (up && in_search && !clear),
    .count   (cand_key),
    .primed  (primed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = SEARCH;
    end else if (test && match) begin
      state_next = HIT;
    end else if (test && last) begin
      state_next = EXHAUSTED;
    end
  end

  // Zero-latency answer so the controller can branch in the same S2 cycle.
  assign key_found = (in_search && en1 && (match || last)) || in_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_end_reg      <= '0;
      target_ct_reg    <= '0;
      found_key_reg    <= '0;
      attempts_reg     <= '0;
      result_valid_reg <= 1'b0;
    end else if (clear) begin
      key_end_reg      <= key_end;
      target_ct_reg    <= target_ct;
      attempts_reg     <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      if (test) begin
        attempts_reg <= sat_inc(attempts_reg);
        if (match) begin
          found_key_reg <= cand_key;
        end
      end
      if (en2 && in_done) begin
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign key_hit      = (state_reg == HIT);
  assign exhausted    = (state_reg == EXHAUSTED);
  assign found_key    = found_key_reg;
  assign attempts     = attempts_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_keysearch_datapath.sv
// Randomised key-search bench: searches are predicted from range arithmetic,
// queued at issue time and compared by a monitor when result_valid rises.
import keysearch_pkg::*;

module tb_keysearch_datapath;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic [KEY_W-1:0] key_start;
  logic [KEY_W-1:0] key_end;
  logic [BLK_W-1:0] target_ct;
  logic             up, en1, en2;
  logic [KEY_W-1:0] cand_key;
  logic [BLK_W-1:0] des_ct;
  logic             key_found, key_hit, exhausted, result_valid;
  logic [KEY_W-1:0] found_key, attempts;

  always #5 clk = ~clk;

  // Stand-in for the DES core: any injective function of the key will do.
  function automatic logic [BLK_W-1:0] ct_of(input logic [KEY_W-1:0] k);
    return {8'hC3, k ^ 56'h5A_A5F0_0F3C_C396};
  endfunction

  assign des_ct = ct_of(cand_key);

  keysearch_datapath dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .key_start    (key_start),
    .key_end      (key_end),
    .target_ct    (target_ct),
    .up           (up),
    .en1          (en1),
    .en2          (en2),
    .cand_key     (cand_key),
    .des_ct       (des_ct),
    .key_found    (key_found),
    .key_hit      (key_hit),
    .exhausted    (exhausted),
    .found_key    (found_key),
    .result_valid (result_valid),
    .attempts     (attempts)
  );

  typedef struct {
    logic             hit;
    logic [KEY_W-1:0] found;
    logic [KEY_W-1:0] att;
    logic [KEY_W-1:0] cand;
  } exp_t;

  exp_t             sbq[$];
  int               checks = 0;
  int               errors = 0;
  logic [KEY_W-1:0] last_found = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard entry per completed search.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid && !rv_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: result_valid with no expected search queued");
      end else begin
        e = sbq.pop_front();
        check("key_hit",   64'(key_hit),   64'(e.hit));
        check("exhausted", 64'(exhausted), 64'(!e.hit));
        check("found_key", 64'(found_key), 64'(e.found));
        check("attempts",  64'(attempts),  64'(e.att));
        check("cand_key",  64'(cand_key),  64'(e.cand));
        $display("search done: hit=%0d found=%h attempts=%0d", key_hit, found_key, attempts);
      end
    end
    rv_prev = result_valid;
  end

  task automatic do_clear(input logic [KEY_W-1:0] s, input logic [KEY_W-1:0] e,
                          input logic [KEY_W-1:0] tk);
    clear = 1'b1; key_start = s; key_end = e; target_ct = ct_of(tk);
    tick();
    clear = 1'b0;
    check("clr_attempts", 64'(attempts), 64'd0);
    check("clr_cand",     64'(cand_key), 64'(s));
    check("clr_flags",    {61'd0, key_hit, exhausted, result_valid}, 64'd0);
    check("clr_found",    64'(found_key), 64'(last_found));
  endtask

  task automatic run_search(input logic [KEY_W-1:0] s, input logic [KEY_W-1:0] e,
                            input logic [KEY_W-1:0] tk, input bit do_en2);
    exp_t             x;
    logic [KEY_W-1:0] span;
    logic [KEY_W-1:0] off;
    int               nen1;
    bit               kf;
    span = e - s;
    off  = tk - s;
    if (off <= span) begin
      x.hit = 1'b1; x.found = tk; x.att = off + KEY_W'(1); x.cand = tk;
    end else begin
      x.hit = 1'b0; x.found = last_found; x.att = span + KEY_W'(1); x.cand = e;
    end
    do_clear(s, e, tk);
    nen1 = 0;
    kf   = 1'b0;
    for (int i = 0; i < 200 && !kf; i++) begin
      up = 1'b1; tick(); up = 1'b0;
      en1 = 1'b1; #1; kf = key_found; tick(); en1 = 1'b0;
      nen1++;
    end
    if (!kf) begin
      checks++; errors++;
      $display("FAIL search_timeout: key_found never rose, start=%h end=%h", s, e);
    end
    check("en1_to_found", 64'(nen1), 64'(x.att));
    // Strobes after termination must leave everything frozen.
    up = 1'b1; en1 = 1'b1; tick(); up = 1'b0; en1 = 1'b0; tick();
    if (do_en2) begin
      sbq.push_back(x);
      en2 = 1'b1; tick(); en2 = 1'b0; tick(); tick();
      check("rv_hold", 64'(result_valid), 64'd1);
    end else begin
      check("nohold_hit",  64'(key_hit),  64'(x.hit));
      check("nohold_att",  64'(attempts), 64'(x.att));
      check("nohold_cand", 64'(cand_key), 64'(x.cand));
    end
    if (x.hit) last_found = tk;
    $display("search issued: start=%h end=%h target_key=%h expect_hit=%0d attempts=%0d",
             s, e, tk, x.hit, nen1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [KEY_W-1:0] s, e, tk;
    int               n;
    reset_n = 1'b0; clear = 1'b0; up = 1'b0; en1 = 1'b0; en2 = 1'b0;
    key_start = '0; key_end = '0; target_ct = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {60'd0, key_found, key_hit, exhausted, result_valid}, 64'd0);
    check("rst_cand", 64'(cand_key), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Strobes before any clear are ignored.
    up = 1'b1; tick(); up = 1'b0;
    en1 = 1'b1; #1; check("idle_key_found", 64'(key_found), 64'd0); tick(); en1 = 1'b0;
    en2 = 1'b1; tick(); en2 = 1'b0;
    check("idle_cand", 64'(cand_key), 64'd0);
    check("idle_attempts", 64'(attempts), 64'd0);
    check("idle_flags", {61'd0, key_hit, exhausted, result_valid}, 64'd0);

    run_search(56'd5, 56'd9, 56'd5, 1'b1);
    run_search(56'd0, 56'd100, 56'd37, 1'b1);
    run_search(56'd10, 56'd12, 56'd200, 1'b1);
    run_search(56'hFF_FFFF_FFFF_FFFE, 56'd1, 56'd0, 1'b1);
    run_search(56'd20, 56'd25, 56'd25, 1'b1);
    run_search(56'd77, 56'd77, 56'd77, 1'b1);
    run_search(56'd78, 56'd78, 56'd79, 1'b1);

    // Asynchronous reset in the middle of a search.
    do_clear(56'd1000, 56'd2000, 56'd1500);
    repeat (5) begin
      up = 1'b1; tick(); up = 1'b0; en1 = 1'b1; tick(); en1 = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_flags", {60'd0, key_found, key_hit, exhausted, result_valid}, 64'd0);
    check("mid_rst_cand", 64'(cand_key), 64'd0);
    check("mid_rst_attempts", 64'(attempts), 64'd0);
    check("mid_rst_found", 64'(found_key), 64'd0);
    last_found = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Left in HIT without en2; the next clear lands in HIT.
    run_search(56'd300, 56'd320, 56'd304, 1'b0);

    for (int i = 0; i < 15; i++) begin
      n = $urandom_range(1, 40);
      if ($urandom_range(0, 3) == 0)
        s = 56'hFF_FFFF_FFFF_FFFF - KEY_W'($urandom_range(0, 20));
      else
        s = {24'd0, 32'($urandom)};
      e = s + KEY_W'(n - 1);
      if ($urandom_range(0, 3) != 0)
        tk = s + KEY_W'($urandom_range(0, n - 1));
      else
        tk = e + KEY_W'(1 + $urandom_range(0, 5));
      run_search(s, e, tk, ($urandom_range(0, 4) != 0));
    end

    repeat (3) tick();
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keysearch_datapath.md
# keysearch_datapath

Datapath responder for the DES key-search control FSM. It consumes the controller's `up`, `en1` and `en2` strobes and returns `key_found`. It holds the candidate-key counter and presents the candidate to an external combinational DES core. It compares the resulting ciphertext against the target and latches the winning key, or flags that the range was exhausted. It sits between the control FSM and the DES core, with the range/target inputs and result outputs exposed to the host.

## Interface
- `KEY_W`, 56, candidate key width
- `BLK_W`, 64, ciphertext block width

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous; loads a new search, priority over all strobes
- `key_start`  in  KEY_W  first key of range, sampled on `clear`
- `key_end`  in  KEY_W  last key of range (inclusive), sampled on `clear`
- `target_ct`  in  BLK_W  ciphertext to match, sampled on `clear`
- `up`  in  1  advance candidate (controller S1)
- `en1`  in  1  test/store cycle (controller S2)
- `en2`  in  1  result-hold (controller S3)
- `cand_key`  out  KEY_W  registered candidate to DES core
- `des_ct`  in  BLK_W  DES ciphertext of `cand_key`, combinational from core
- `key_found`  out  1  search terminated (hit or exhausted), to controller
- `key_hit`  out  1  terminated on a true match
- `exhausted`  out  1  terminated at `key_end` without match
- `found_key`  out  KEY_W  matching key, valid when `key_hit`
- `result_valid`  out  1  high after first `en2` cycle following termination
- `attempts`  out  KEY_W  keys tested since `clear`

## Operation
- Status FSM states:
  - IDLE (reset)
  - SEARCH (after `clear`)
  - HIT
  - EXHAUSTED
- Transitions:
  - SEARCH→HIT on `en1 & match`.
  - SEARCH→EXHAUSTED on `en1 & !match & last`.
  - HIT/EXHAUSTED→SEARCH only via `clear`.
- Definitions: `match = (des_ct == target_ct_reg)` and `last = (cand_key == key_end_reg)`.
- `clear` (any state):
  - `cand_key <= key_start`, `primed <= 0`, `attempts <= 0`.
  - `key_hit`, `exhausted` and `result_valid` go to 0; `found_key` is unchanged.
  - The range and target registers are loaded.
- `up` in SEARCH:
  - If `!primed`, set `primed`; `cand_key` is unchanged, so the first tested key is `key_start`.
  - Else `cand_key <= cand_key + 1` mod 2^KEY_W.
- `en1` in SEARCH:
  - `attempts` increments, saturating at all-ones.
  - On `match`: `found_key <= cand_key` and `key_hit <= 1`.
  - Else if `last`: `exhausted <= 1`.
- `key_found` is combinational: `(state==SEARCH & en1 & (match | last)) | state==HIT | state==EXHAUSTED`. It is therefore valid in the same cycle the controller samples it in S2.
- `en2` while HIT/EXHAUSTED: `result_valid <= 1`, held until `clear`. Dropping `en2` does not clear results.
- Strobes in IDLE: `up`/`en1`/`en2` are ignored; `key_found` is 0.
- Strobes in HIT/EXHAUSTED: `up` and `en1` are ignored; `cand_key` and `attempts` are frozen.
- Simultaneous `up` and `en1`: `en1` test uses the pre-increment `cand_key`, then the increment applies. The controller never does this, but the behaviour is defined.
- Wrap-around: if `key_end < key_start`, the search wraps through all-ones to 0. If `key_start == key_end`, exactly one key is tested. A match on the `last` key reports HIT, not EXHAUSTED.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - `cand_key` = 0, `found_key` = 0, `attempts` = 0.
  - Range and target registers = 0.
- `cand_key` changes one cycle after `up`. `des_ct` must settle within that cycle; the DES core is outside this block's timing.
- Throughput: one key per two cycles (S1 `up`, S2 `en1`).
- `key_found` has zero latency from `en1`. `key_hit`, `exhausted` and `found_key` are registered, visible one cycle after the deciding `en1`.
- `result_valid` is registered, one cycle after first `en2` in HIT/EXHAUSTED.
- Reset mid-search: all state returns to reset values at once, asynchronously; deassertion is synchronous to `clk`.

## Structure
- Package `keysearch_pkg`: `KEY_W` and `BLK_W` localparams, `status_t` enum {IDLE, SEARCH, HIT, EXHAUSTED}.
- Sub-module `key_counter`: loadable KEY_W up-counter with prime bit, `load`/`inc` inputs and wrap mod 2^KEY_W.
- Comparator, status FSM and result registers stay in the top.

## Test plan
- Match at start: stub DES as `des_ct = {8'h0, cand_key}`, target `64'h0000_0000_0000_0005`; `clear` with start=5, end=9; one `up` then `en1` → `key_found`=1 during `en1`; next cycle `key_hit`=1, `found_key`=5, `attempts`=1.
- Mid-range match: start=0, end=100, target = ct of 37; strobe up/en1 pairs → `key_found` on 38th `en1`; `found_key`=37, `attempts`=38. `en2` → `result_valid`=1 next cycle and stays after `en2` drops.
- Exhaustion: start=10, end=12, no matching target → `key_found` on 3rd `en1`; `exhausted`=1, `key_hit`=0, `attempts`=3. Further `up`/`en1` leave `cand_key`=12.
- Wrap: start=56'hFF_FFFF_FFFF_FFFE, end=1, target = ct of 0 → `cand_key` goes …FE, …FF, 0; `key_hit` with `found_key`=0, `attempts`=3.
- Reset/clear mid-search: after 5 keys, pull `reset_n` low → all outputs 0 immediately. Then `clear` during HIT → flags 0, `attempts`=0, `cand_key`=new `key_start`.
- IDLE strobes: `up`/`en1` pulses before any `clear` → `key_found`=0, `cand_key`=0, `attempts`=0.
